// File: rtl/qspi_target.sv
// -----------------------------------------------------------------------------
// qspi_target
//   Quad-SPI memory responder. Target end of the qspi line-fill/write-back
//   link: decodes a quad command and address, serves reads from and absorbs
//   writes into an internal byte array. Used as on-chip test RAM and as a
//   stand-in for external flash/PSRAM.
//
//   Commands (all transfers nibble-wide, MSB nibble first):
//     8'hEB  quad read : CMD -> ADDR -> DUMMY -> RDATA (burst until cs_n rise)
//     8'h38  quad write: CMD -> ADDR -> WDATA          (burst until cs_n rise)
//     8'h9F  JEDEC ID  : CMD -> ID (only when QSPI_TGT_ID_EN is defined)
//     other            : IGNORE, outputs stay undriven until cs_n rise
//
//   Optional feature macro: QSPI_TGT_ID_EN (adds the 0x9F ID command and the
//   JEDEC parameter). Without it 0x9F is an unknown command.
//
// Ports
//   clk        in   system clock, all flops live here
//   reset      in   asynchronous active-low reset
//   sck        in   QSPI clock, asynchronous, oversampled (clk >= 4x sck)
//   cs_n       in   chip select, active low
//   io_in      in   [3:0] QSPI data in, bit 3 is the MSB
//   io_out     out  [3:0] QSPI data out
//   io_oe      out  [3:0] output enable, 4'hF only while driving read/ID data
//   ld_we      in   backdoor write strobe, honoured only while cs_n is high
//   ld_addr    in   [$clog2(DEPTH)-1:0] backdoor byte address
//   ld_data    in   [7:0] backdoor byte
//   active     out  high from the first command nibble until cs_n returns high
//   dbg_state  out  [2:0] current FSM state (encoding of state_e)
// -----------------------------------------------------------------------------
module qspi_target #(
  parameter int AW    = 24,
  parameter int DEPTH = 256,
  parameter int DUMMY = 4
`ifdef QSPI_TGT_ID_EN
  ,
  parameter logic [23:0] JEDEC = 24'hEF4018
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     cs_n,
  input  logic [3:0]               io_in,
  output logic [3:0]               io_out,
  output logic [3:0]               io_oe,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [7:0]               ld_data,
  output logic                     active,
  output logic [2:0]               dbg_state
);

  localparam int AI  = $clog2(DEPTH);  // array index width
  localparam int NIB = AW / 4;         // address nibbles on the wire
  localparam int CW  = 8;              // shared counter width

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_ID     = 3'd6,
    S_IGNORE = 3'd7
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and sck edge detect
  // ---------------------------------------------------------------------------
  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       cs_s1_q, cs_s2_q;
  logic [3:0] io_s1_q, io_s2_q;

  // cs sync resets to "deselected" so a stale low level cannot look like a
  // transfer in progress right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      io_s1_q  <= 4'h0;
      io_s2_q  <= 4'h0;
    end else begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      cs_s1_q  <= cs_n;
      cs_s2_q  <= cs_s1_q;
      io_s1_q  <= io_in;
      io_s2_q  <= io_s1_q;
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise =  sck_s2_q & ~sck_s3_q;
  assign sck_fall = ~sck_s2_q &  sck_s3_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;        // address nibbles / dummy cycles / ID byte
  logic [AI-1:0] addr_q, addr_d;      // only the low AI address bits matter
  logic [3:0]    cmd_hi_q, cmd_hi_d;  // first command nibble
  logic          rd_cmd_q, rd_cmd_d;  // 1: read command, 0: write command
  logic          nib_q, nib_d;        // 0: high nibble next, 1: low nibble next
  logic [3:0]    wbuf_q, wbuf_d;      // held high nibble of a write byte
  logic [3:0]    io_out_q, io_out_d;
  logic [3:0]    io_oe_q, io_oe_d;
  logic          active_q, active_d;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    rd_byte;
  logic [7:0]    cmd_byte;

  assign rd_byte  = mem_q[addr_q];
  assign cmd_byte = {cmd_hi_q, io_s2_q};

`ifdef QSPI_TGT_ID_EN
  logic [7:0] id_byte;
  always_comb begin
    id_byte = 8'hFF;
    case (cnt_q)
      8'd0:    id_byte = JEDEC[23:16];
      8'd1:    id_byte = JEDEC[15:8];
      8'd2:    id_byte = JEDEC[7:0];
      default: id_byte = 8'hFF;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      cmd_hi_q <= 4'h0;
      rd_cmd_q <= 1'b0;
      nib_q    <= 1'b0;
      wbuf_q   <= 4'h0;
      io_out_q <= 4'h0;
      io_oe_q  <= 4'h0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      cmd_hi_q <= cmd_hi_d;
      rd_cmd_q <= rd_cmd_d;
      nib_q    <= nib_d;
      wbuf_q   <= wbuf_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
      active_q <= active_d;
    end
  end

  // Array contents are deliberately not reset. A bus write can only happen
  // while cs_n is low, so it never collides with an honoured backdoor write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end else if (ld_we && cs_n) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cmd_hi_d  = cmd_hi_q;
    rd_cmd_d  = rd_cmd_q;
    nib_d     = nib_q;
    wbuf_d    = wbuf_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    active_d  = active_q;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;

    if (cs_s2_q) begin
      // Deselect wins over everything, including a half-received byte.
      state_d  = S_IDLE;
      cnt_d    = '0;
      addr_d   = '0;
      nib_d    = 1'b0;
      io_out_d = 4'h0;
      io_oe_d  = 4'h0;
      active_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sck_rise) begin
            cmd_hi_d = io_s2_q;
            active_d = 1'b1;
            state_d  = S_CMD;
          end
        end

        S_CMD: begin
          if (sck_rise) begin
            cnt_d = '0;
            nib_d = 1'b0;
            case (cmd_byte)
              8'hEB: begin
                rd_cmd_d = 1'b1;
                state_d  = S_ADDR;
              end
              8'h38: begin
                rd_cmd_d = 1'b0;
                state_d  = S_ADDR;
              end
`ifdef QSPI_TGT_ID_EN
              8'h9F:   state_d = S_ID;
`endif
              default: state_d = S_IGNORE;
            endcase
          end
        end

        S_ADDR: begin
          if (sck_rise) begin
            // Shift in MSB nibble first; upper wire bits fall off the top.
            addr_d = AI'({addr_q, io_s2_q});
            if (cnt_q == CW'(NIB - 1)) begin
              cnt_d   = '0;
              nib_d   = 1'b0;
              state_d = rd_cmd_q ? S_DUMMY : S_WDATA;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        S_DUMMY: begin
          // Count DUMMY rises; the fall after the last one drives data so the
          // host can sample it on the following rise.
          if (sck_rise && (cnt_q != CW'(DUMMY))) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (sck_fall && (cnt_q == CW'(DUMMY))) begin
            io_oe_d  = 4'hF;
            io_out_d = rd_byte[7:4];
            nib_d    = 1'b1;
            state_d  = S_RDATA;
          end
        end

        S_RDATA: begin
          if (sck_fall) begin
            if (nib_q) begin
              io_out_d = rd_byte[3:0];
              addr_d   = addr_q + AI'(1);
              nib_d    = 1'b0;
            end else begin
              io_out_d = rd_byte[7:4];
              nib_d    = 1'b1;
            end
          end
        end

        S_WDATA: begin
          if (sck_rise) begin
            if (nib_q) begin
              mem_we    = 1'b1;
              mem_wdata = {wbuf_q, io_s2_q};
              addr_d    = addr_q + AI'(1);
              nib_d     = 1'b0;
            end else begin
              wbuf_d = io_s2_q;
              nib_d  = 1'b1;
            end
          end
        end

`ifdef QSPI_TGT_ID_EN
        S_ID: begin
          if (sck_fall) begin
            io_oe_d = 4'hF;
            if (nib_q) begin
              io_out_d = id_byte[3:0];
              nib_d    = 1'b0;
              // Saturate at 3 so the tail keeps returning 8'hFF.
              if (cnt_q != CW'(3)) begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              io_out_d = id_byte[7:4];
              nib_d    = 1'b1;
            end
          end
        end
`endif

        default: begin
          // S_IGNORE (and S_ID when the ID feature is absent): wait for cs_n.
        end
      endcase
    end
  end

  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;
  assign active    = active_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qspi_target.sv
// -----------------------------------------------------------------------------
// tb_qspi_target
//   Self-checking bench for qspi_target. A byte-array model mirrors every
//   backdoor load and bus write; read bursts push expected nibbles onto
//   exp_q when the command is issued and pop them as the DUT drives data.
// -----------------------------------------------------------------------------
module tb_qspi_target;

  localparam int H     = 8;   // sck half period in clk cycles
  localparam int DUMMY = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       cs_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       active;
  logic [2:0] dbg_state;

  qspi_target dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .cs_n      (cs_n),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .active    (active),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [7:0] model_mem [256];
  logic [3:0] wr_nibs [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all input changes happen on the falling clk edge)
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    wait_clk(1);
    ld_we   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic send_nib(input logic [3:0] v);
    io_in = v;
    wait_clk(H);
    sck = 1'b1;
    wait_clk(H);
    sck = 1'b0;
  endtask

  task automatic begin_xfer();
    cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic end_xfer();
    wait_clk(H);
    cs_n  = 1'b1;
    io_in = 4'h0;
    wait_clk(3);
    check("end_oe", io_oe, 4'h0);
    check("end_active", active, 1'b0);
    check("end_state", dbg_state, 3'd0);
    wait_clk(H);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_nib(b[7:4]);
    check("cmd_active", active, 1'b1);
    send_nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic do_dummy();
    for (int i = 0; i < DUMMY; i++) begin
      io_in = 4'h0;
      wait_clk(H);
      check("dummy_oe", io_oe, 4'h0);
      sck = 1'b1;
      wait_clk(H);
      sck = 1'b0;
    end
  endtask

  // Sample near the end of the low phase, then clock the host side.
  task automatic read_nib(input string tag);
    logic [3:0] e;
    wait_clk(H);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    check(tag, io_out, e);
    check({tag, "_oe"}, io_oe, 4'hF);
    sck = 1'b1;
    wait_clk(H);
    sck = 1'b0;
  endtask

  task automatic read_burst(input logic [23:0] a, input int nbytes, input string tag);
    logic [7:0] idx;
    logic [7:0] b;
    begin_xfer();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < nbytes; i++) begin
      idx = a[7:0] + 8'(i);
      b   = model_mem[idx];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    do_dummy();
    for (int i = 0; i < 2 * nbytes; i++) read_nib(tag);
    end_xfer();
  endtask

  task automatic write_burst(input logic [23:0] a, input int n);
    logic [7:0] idx;
    begin_xfer();
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < n; i++) send_nib(wr_nibs[i]);
    // Only whole bytes land; a trailing odd nibble is discarded.
    for (int i = 0; i + 1 < n; i += 2) begin
      idx = a[7:0] + 8'(i / 2);
      model_mem[idx] = {wr_nibs[i], wr_nibs[i+1]};
    end
    end_xfer();
  endtask

  task automatic ignore_cmd(input logic [7:0] b);
    begin_xfer();
    send_cmd(b);
    for (int i = 0; i < 6; i++) begin
      io_in = 4'($urandom_range(0, 15));
      wait_clk(H);
      check("ign_oe", io_oe, 4'h0);
      sck = 1'b1;
      wait_clk(H);
      sck = 1'b0;
    end
    end_xfer();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [23:0] ra;

    reset   = 1'b0;
    sck     = 1'b0;
    cs_n    = 1'b0;
    io_in   = 4'h0;
    ld_we   = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;

    // 1. Reset held with bus activity: outputs stay quiet.
    wait_clk(2);
    for (int i = 0; i < 4; i++) begin
      io_in = 4'($urandom_range(0, 15));
      sck = 1'b1;
      wait_clk(H);
      check("rst_oe", io_oe, 4'h0);
      check("rst_out", io_out, 4'h0);
      check("rst_active", active, 1'b0);
      sck = 1'b0;
      wait_clk(H);
      check("rst_oe_lo", io_oe, 4'h0);
    end
    io_in = 4'h0;
    reset = 1'b1;
    wait_clk(4);
    check("rst_state", dbg_state, 3'd0);
    check("rst_active_rel", active, 1'b0);
    cs_n = 1'b1;
    wait_clk(4);

    // 2. Preload and read back.
    ld(8'h10, 8'hA1);
    ld(8'h11, 8'hB2);
    ld(8'h12, 8'hC3);
    ld(8'h13, 8'hD4);
    ld(8'h20, 8'hEE);
    ld(8'h21, 8'($urandom_range(0, 255)));
    read_burst(24'h000010, 4, "rd10");

    // 3. Write across the top of the array, then read across the wrap.
    for (int i = 0; i < 6; i++) wr_nibs[i] = 4'(i + 1);
    write_burst(24'h0000FE, 6);
    read_burst(24'h0000FE, 3, "rdwrap");

    // 4. Odd nibble count: trailing nibble dropped.
    wr_nibs[0] = 4'h7;
    wr_nibs[1] = 4'h8;
    wr_nibs[2] = 4'h9;
    write_burst(24'h000020, 3);
    read_burst(24'h000020, 2, "rd20");

    // 5. Abort mid-address, then a clean read; then an unknown command.
    begin_xfer();
    send_cmd(8'hEB);
    send_nib(4'h0);
    send_nib(4'h0);
    send_nib(4'h3);
    end_xfer();
    read_burst(24'h000010, 1, "rdabort");
    ignore_cmd(8'h5A);

    // 6. JEDEC ID.
`ifdef QSPI_TGT_ID_EN
    begin_xfer();
    send_cmd(8'h9F);
    exp_q.push_back(4'hE); exp_q.push_back(4'hF);
    exp_q.push_back(4'h4); exp_q.push_back(4'h0);
    exp_q.push_back(4'h1); exp_q.push_back(4'h8);
    exp_q.push_back(4'hF); exp_q.push_back(4'hF);
    for (int i = 0; i < 8; i++) read_nib("id");
    end_xfer();
`else
    ignore_cmd(8'h9F);
`endif

    // Random burst with junk in the ignored upper address bits.
    ra = {16'($urandom_range(0, 65535)), 8'(8'h40 + 8'($urandom_range(0, 8)))};
    for (int i = 0; i < 8; i++) wr_nibs[i] = 4'($urandom_range(0, 15));
    write_burst(ra, 8);
    ra[23:8] = 16'($urandom_range(0, 65535));
    read_burst(ra, 4, "rdrand");

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
